// File: rtl/stream_serializer.sv
// Width-down converter: accepts one PAYLOAD_BITS word per handshake and emits
// it as PAYLOAD_BITS/BEAT_BITS beats, least-significant beat first, flagging the final beat.
module stream_serializer #(
    parameter int PAYLOAD_BITS = 128,
    parameter int BEAT_BITS    = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [PAYLOAD_BITS-1:0] din,
    input  logic                    val_in,
    output logic                    ready_upward,
    output logic [BEAT_BITS-1:0]    dout,
    output logic                    val_out,
    output logic                    last_out,
    input  logic                    ready_downward,
    output logic [31:0]             words_out
);

    localparam int RATIO = PAYLOAD_BITS / BEAT_BITS;
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    generate
        if ((PAYLOAD_BITS % BEAT_BITS) != 0 || RATIO < 2) begin : g_bad_params
            $error("stream_serializer: PAYLOAD_BITS must be a multiple (>=2x) of BEAT_BITS");
        end
    endgenerate

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                  state, state_next;
    logic [PAYLOAD_BITS-1:0] shift_reg, shift_next;
    logic [IDX_W-1:0]        idx, idx_next;
    logic [31:0]             words_next;
    logic                    is_last;
    logic                    in_xfer;
    logic                    out_xfer;

    // Outputs decode only registered state, except ready_upward which also
    // sees ready_downward so a new word can load on the last-beat edge.
    always_comb begin
        is_last      = (state == SEND) && (idx == LAST_IDX);
        val_out      = (state == SEND);
        last_out     = is_last;
        dout         = shift_reg[BEAT_BITS-1:0];
        ready_upward = (state == IDLE) || (is_last && ready_downward);
    end

    assign in_xfer  = val_in && ready_upward;
    assign out_xfer = val_out && ready_downward;

    always_comb begin
        state_next = state;
        shift_next = shift_reg;
        idx_next   = idx;
        words_next = words_out;
        case (state)
            IDLE: begin
                if (in_xfer) begin
                    shift_next = din;
                    idx_next   = '0;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (out_xfer) begin
                    if (!is_last) begin
                        shift_next = shift_reg >> BEAT_BITS;
                        idx_next   = idx + IDX_W'(1);
                    end else begin
                        words_next = words_out + 32'd1;
                        if (in_xfer) begin
                            shift_next = din;
                            idx_next   = '0;
                        end else begin
                            // No shift here: dout keeps showing the last beat while idle.
                            state_next = IDLE;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            idx       <= '0;
            words_out <= '0;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            idx       <= idx_next;
            words_out <= words_next;
        end
    end

endmodule

// File: tb/tb_stream_serializer.sv
// Self-checking bench for stream_serializer: vector table for single-word and
// backpressure cycles, scoreboard of expected beats for all traffic.
module tb_stream_serializer;

    localparam int PB    = 128;
    localparam int BB    = 32;
    localparam int RATIO = PB / BB;

    logic          clk = 1'b0;
    logic          reset;
    logic [PB-1:0] din;
    logic          val_in;
    logic          ready_upward;
    logic [BB-1:0] dout;
    logic          val_out;
    logic          last_out;
    logic          ready_downward;
    logic [31:0]   words_out;

    always #5 clk = ~clk;

    stream_serializer #(.PAYLOAD_BITS(PB), .BEAT_BITS(BB)) dut (
        .clk            (clk),
        .reset          (reset),
        .din            (din),
        .val_in         (val_in),
        .ready_upward   (ready_upward),
        .dout           (dout),
        .val_out        (val_out),
        .last_out       (last_out),
        .ready_downward (ready_downward),
        .words_out      (words_out)
    );

    typedef struct packed {
        logic [BB-1:0] data;
        logic          last;
    } beat_t;

    typedef struct {
        logic          vi;
        logic          rd;
        logic [PB-1:0] din;
        logic          ev;
        logic          el;
        logic          eru;
        logic [BB-1:0] ed;
        logic [31:0]   ew;
    } vec_t;

    beat_t sb[$];
    beat_t exp_beat;
    int    n_tests = 0;
    int    n_fail  = 0;

    task automatic chk(input string name, input logic [PB-1:0] act, input logic [PB-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change #1 after posedge, so at negedge they hold what the next edge samples.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            sb.delete();
        end else begin
            if (val_out && ready_downward) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got beat %0h expected none", dout);
                end else begin
                    exp_beat = sb.pop_front();
                    chk("sb_data", dout, exp_beat.data);
                    chk("sb_last", last_out, exp_beat.last);
                end
            end
            if (val_in && ready_upward) begin
                for (int b = 0; b < RATIO; b++)
                    sb.push_back('{data: din[b*BB +: BB], last: (b == RATIO - 1)});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    localparam logic [PB-1:0] W = 128'h33333333_22222222_11111111_00000000;

    vec_t          vt[18];
    logic [PB-1:0] bw[3];
    logic [PB-1:0] cur;
    logic [PB-1:0] w2;
    logic [PB-1:0] w3;
    int            acc;
    int            cyc;

    initial begin
        reset = 1'b1; val_in = 1'b0; ready_downward = 1'b0; din = '0;

        //                vi    rd    din     val   last  ru    dout          words
        vt[0]  = '{1'b1, 1'b1, W,      1'b0, 1'b0, 1'b1, 32'h00000000, 32'd0};
        vt[1]  = '{1'b0, 1'b1, '0,     1'b1, 1'b0, 1'b0, 32'h00000000, 32'd0};
        vt[2]  = '{1'b0, 1'b1, '0,     1'b1, 1'b0, 1'b0, 32'h11111111, 32'd0};
        vt[3]  = '{1'b0, 1'b1, '0,     1'b1, 1'b0, 1'b0, 32'h22222222, 32'd0};
        vt[4]  = '{1'b0, 1'b1, '0,     1'b1, 1'b1, 1'b1, 32'h33333333, 32'd0};
        vt[5]  = '{1'b0, 1'b1, '0,     1'b0, 1'b0, 1'b1, 32'h33333333, 32'd1};
        vt[6]  = '{1'b1, 1'b1, W,      1'b0, 1'b0, 1'b1, 32'h33333333, 32'd1};
        vt[7]  = '{1'b0, 1'b1, '0,     1'b1, 1'b0, 1'b0, 32'h00000000, 32'd1};
        for (int i = 8; i <= 12; i++)
            vt[i] = '{1'b0, 1'b0, '0,  1'b1, 1'b0, 1'b0, 32'h11111111, 32'd1};
        vt[13] = '{1'b0, 1'b1, '0,     1'b1, 1'b0, 1'b0, 32'h11111111, 32'd1};
        vt[14] = '{1'b0, 1'b1, '0,     1'b1, 1'b0, 1'b0, 32'h22222222, 32'd1};
        vt[15] = '{1'b0, 1'b0, '0,     1'b1, 1'b1, 1'b0, 32'h33333333, 32'd1};
        vt[16] = '{1'b0, 1'b1, '0,     1'b1, 1'b1, 1'b1, 32'h33333333, 32'd1};
        vt[17] = '{1'b0, 1'b1, '0,     1'b0, 1'b0, 1'b1, 32'h33333333, 32'd2};

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_val", val_out, 1'b0);
        chk("rst_last", last_out, 1'b0);
        chk("rst_dout", dout, '0);
        chk("rst_words", words_out, '0);
        chk("rst_ready", ready_upward, 1'b1);
        @(posedge clk); #1;
        reset = 1'b0;

        // Single word followed by a word held under 5 cycles of backpressure on beat 1.
        for (int i = 0; i < 18; i++) begin
            val_in = vt[i].vi; ready_downward = vt[i].rd; din = vt[i].din;
            @(negedge clk);
            chk($sformatf("vec%0d_val", i), val_out, vt[i].ev);
            chk($sformatf("vec%0d_last", i), last_out, vt[i].el);
            chk($sformatf("vec%0d_ready", i), ready_upward, vt[i].eru);
            chk($sformatf("vec%0d_dout", i), dout, vt[i].ed);
            chk($sformatf("vec%0d_words", i), words_out, vt[i].ew);
            @(posedge clk); #1;
        end

        // Back-to-back words with val_in continuous.
        bw[0] = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
        bw[1] = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
        bw[2] = 128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0;
        for (int c = 0; c <= 13; c++) begin
            ready_downward = 1'b1;
            val_in = (c < 12);
            din = (c < 12) ? bw[c/4] : '0;
            @(negedge clk);
            if (c == 0 || c == 13) begin
                chk($sformatf("b2b%0d_val", c), val_out, 1'b0);
                chk($sformatf("b2b%0d_ready", c), ready_upward, 1'b1);
            end else begin
                chk($sformatf("b2b%0d_val", c), val_out, 1'b1);
                chk($sformatf("b2b%0d_last", c), last_out, (c % 4) == 0);
                chk($sformatf("b2b%0d_ready", c), ready_upward, (c % 4) == 0);
                chk($sformatf("b2b%0d_dout", c), dout, bw[(c-1)/4][((c-1)%4)*BB +: BB]);
            end
            @(posedge clk); #1;
        end
        val_in = 1'b0;
        @(negedge clk);
        chk("b2b_words", words_out, 32'd5);
        @(posedge clk); #1;

        // Random valid/ready stalls over 200 words.
        acc = 0; cyc = 0;
        cur = {$urandom, $urandom, $urandom, $urandom};
        while (acc < 200 && cyc < 20000) begin
            val_in = ($urandom_range(0, 3) != 0);
            ready_downward = ($urandom_range(0, 2) != 0);
            din = cur;
            @(negedge clk);
            if (val_in && ready_upward) begin
                acc++;
                cur = {$urandom, $urandom, $urandom, $urandom};
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("rand_accepted", acc, 200);
        val_in = 1'b0; ready_downward = 1'b1;
        cyc = 0;
        while (cyc < 100) begin
            @(negedge clk);
            if (sb.size() == 0 && val_out == 1'b0) cyc = 1000;
            @(posedge clk); #1;
            cyc++;
        end
        chk("rand_drained", sb.size(), 0);
        chk("rand_words", words_out, 32'd205);

        // Reset one cycle after beat 1 of a word transfers.
        w2 = 128'hDDDDDDD3_DDDDDDD2_DDDDDDD1_DDDDDDD0;
        w3 = 128'hEEEEEEE3_EEEEEEE2_EEEEEEE1_EEEEEEE0;
        val_in = 1'b1; din = w2; ready_downward = 1'b1;
        @(posedge clk); #1;
        val_in = 1'b0; din = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_val", val_out, 1'b0);
        chk("mid_rst_last", last_out, 1'b0);
        chk("mid_rst_dout", dout, '0);
        chk("mid_rst_words", words_out, '0);
        chk("mid_rst_ready", ready_upward, 1'b1);
        @(posedge clk); #1;
        val_in = 1'b1; din = w3;
        @(posedge clk); #1;
        val_in = 1'b0; din = '0;
        @(negedge clk);
        chk("post_rst_beat0", dout, w3[BB-1:0]);
        chk("post_rst_val", val_out, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        @(negedge clk);
        chk("post_rst_words", words_out, 32'd1);
        chk("post_rst_idle", val_out, 1'b0);
        chk("final_sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
